alu_seq: RTL and testbench

- Multi-cycle, parametrised successor to the Hmmm combinational ALU.
- Width is set by a parameter. Add and subtract finish in one cycle. Multiply uses a shift-add loop; divide and modulo use a restoring-division loop.
- Flags and result are registered and held until the next operation.
- Sits between the Hmmm register-file temp registers and the shared result bus. The control FSM starts an operation and waits for done.

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle signed ALU: add/sub (1 cycle), shift-add mul, restoring div/mod.
// Optional macro ALU_TRISTATE_EN: result is high-Z while oe=0.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] tmp1,
    input  logic [WIDTH-1:0] tmp2,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             sign
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, next_state;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, mag_a, mag_b, quo, rem, res_q;
    logic               sign_a, sign_b, carry_q;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic               is_mul, is_divmod, div_zero, single, last, neg;
    logic [WIDTH-1:0]   sum, diff, mag_b_sh, quo_s, rem_s;
    logic               add_ovf, sub_ovf, mul_ovf, div_ovf, ge;
    logic [2*WIDTH-1:0] mul_next, prod_s;
    logic [WIDTH:0]     rr;

    assign is_mul    = (op_q == OP_MUL);
    assign is_divmod = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign div_zero  = is_divmod && (b_q == '0);
    assign single    = !(is_mul || is_divmod) || div_zero;
    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign neg       = sign_a ^ sign_b;

    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;
    assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);

    // Multiply on magnitudes; sign applied to the full 2*WIDTH product for overflow detection.
    assign mag_b_sh = mag_b >> cnt;
    assign mul_next = acc + (mag_b_sh[0] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0);
    assign prod_s   = neg ? -mul_next : mul_next;
    assign mul_ovf  = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));

    // Restoring division step: shift next dividend bit into the partial remainder.
    assign rr      = {rem, quo[WIDTH-1]};
    assign ge      = (rr >= {1'b0, mag_b});
    assign quo_s   = neg ? -quo : quo;
    assign rem_s   = sign_a ? -rem : rem;
    assign div_ovf = (op_q == OP_DIV) && !neg && quo[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN: begin
                if (single)    next_state = DONE;
                else if (last) next_state = is_mul ? DONE : FIX;
            end
            FIX:     next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            acc     <= '0;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q   <= op;
                    a_q    <= tmp1;
                    b_q    <= tmp2;
                    mag_a  <= tmp1[WIDTH-1] ? -tmp1 : tmp1;
                    mag_b  <= tmp2[WIDTH-1] ? -tmp2 : tmp2;
                    sign_a <= tmp1[WIDTH-1];
                    sign_b <= tmp2[WIDTH-1];
                    acc    <= '0;
                    rem    <= '0;
                    quo    <= tmp1[WIDTH-1] ? -tmp1 : tmp1;
                    cnt    <= '0;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (single) begin
                        case (op_q)
                            OP_ADD: begin res_q <= sum;  carry_q <= add_ovf; end
                            OP_SUB: begin res_q <= diff; carry_q <= sub_ovf; end
                            default: begin res_q <= '0;  carry_q <= div_zero; end
                        endcase
                    end else if (is_mul) begin
                        acc <= mul_next;
                        if (last) begin
                            res_q   <= prod_s[WIDTH-1:0];
                            carry_q <= mul_ovf;
                        end
                    end else begin
                        rem <= WIDTH'(ge ? rr - {1'b0, mag_b} : rr);
                        quo <= {quo[WIDTH-2:0], ge};
                    end
                end
                FIX: begin
                    res_q   <= (op_q == OP_DIV) ? quo_s : rem_s;
                    carry_q <= div_ovf;
                end
                default: ;
            endcase
        end
    end

    assign zero  = (res_q == '0);
    assign sign  = res_q[WIDTH-1];
    assign carry = carry_q;

`ifdef ALU_TRISTATE_EN
    assign result = oe ? res_q : {WIDTH{1'bz}};
`else
    logic unused_oe;
    assign unused_oe = oe;
    assign result    = res_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] tmp1 = '0;
    logic [W-1:0] tmp2 = '0;
    logic         oe = 1'b1;
    logic         busy, done, zero, carry, sign;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .tmp1(tmp1), .tmp2(tmp2),
        .oe(oe), .busy(busy), .done(done), .result(result), .zero(zero),
        .carry(carry), .sign(sign)
    );

    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output int lat);
        longint sa, sb, full, lo, hi;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lo = -(64'sd1 <<< (W - 1));
        hi = (64'sd1 <<< (W - 1)) - 1;
        full = 0;
        c = 1'b0;
        lat = 1;
        case (o)
            3'd0: full = sa + sb;
            3'd1: full = sa - sb;
            3'd2: begin full = sa * sb; lat = W; end
            3'd3: if (sb == 0) c = 1'b1; else begin full = sa / sb; lat = W + 1; end
            3'd4: if (sb == 0) c = 1'b1; else begin full = sa % sb; lat = W + 1; end
            default: ;
        endcase
        if (o <= 3'd3 && (full < lo || full > hi)) c = 1'b1;
        r = full[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return '1;
            3: return {1'b1, {(W-1){1'b0}}};
            4: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] er, prev;
        logic ec, held;
        int lat, n;
        model(o, a, b, er, ec, lat);
        prev = result;
        @(negedge clk);
        start = 1'b1; op = o; tmp1 = a; tmp2 = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); tmp1 = W'($urandom); tmp2 = W'($urandom);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy: got %b want 1", tag, busy); end
        n = 0;
        held = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            if (result !== prev) held = 1'b0;
            @(negedge clk);
            n++;
        end
        total++;
        if (!held) begin bad++; $display("FAIL %s held: result changed while busy, want %h", tag, prev); end
        total++;
        if (n != lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", tag, n, lat); end
        total++;
        if (result !== er) begin bad++; $display("FAIL %s result: got %h want %h", tag, result, er); end
        total++;
        if (carry !== ec) begin bad++; $display("FAIL %s carry: got %b want %b", tag, carry, ec); end
        total++;
        if (zero !== (er == '0)) begin bad++; $display("FAIL %s zero: got %b want %b", tag, zero, er == '0); end
        total++;
        if (sign !== er[W-1]) begin bad++; $display("FAIL %s sign: got %b want %b", tag, sign, er[W-1]); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse: got %b want 0", tag, done); end
    endtask

    task automatic test_reset();
        int seen;
        #2 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, result, zero, carry, sign} !== {2'b00, {W{1'b0}}, 3'b100}) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h zero=%b carry=%b sign=%b want 0 0 0 1 0 0",
                     busy, done, result, zero, carry, sign);
        end
        rst_n = 1'b1;
        do_op(3'd0, W'(3), W'(4), "pre_reset_add");
        @(negedge clk);
        start = 1'b1; op = 3'd2; tmp1 = W'(300); tmp2 = W'(200);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, result, zero, carry} !== {2'b00, {W{1'b0}}, 2'b10}) begin
            bad++;
            $display("FAIL midmul_reset: got busy=%b done=%b result=%h zero=%b carry=%b want 0 0 0 1 0",
                     busy, done, result, zero, carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL midmul_no_done: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_add_sub();
        do_op(3'd0, 16'h7FFF, 16'h0001, "add_ovf");
        do_op(3'd1, W'(5), W'(5), "sub_zero");
        do_op(3'd1, 16'h8000, 16'h0001, "sub_ovf");
        do_op(3'd0, 16'hFFFF, 16'hFFFF, "add_neg");
    endtask

    task automatic test_mul();
        do_op(3'd2, -W'(300), W'(200), "mul_ovf");
        do_op(3'd2, -W'(12), W'(11), "mul_neg");
        do_op(3'd2, 16'h8000, 16'hFFFF, "mul_min_m1");
        do_op(3'd2, W'(181), W'(181), "mul_pos");
    endtask

    task automatic test_div_mod();
        do_op(3'd3, -W'(7), W'(2), "div_neg");
        do_op(3'd4, -W'(7), W'(2), "mod_neg");
        do_op(3'd3, 16'h8000, 16'hFFFF, "div_min_m1");
        do_op(3'd4, 16'h8000, 16'hFFFF, "mod_min_m1");
        do_op(3'd3, W'(5), W'(0), "div_by0");
        do_op(3'd4, W'(5), W'(0), "mod_by0");
        do_op(3'd4, W'(7), -W'(3), "mod_pos_neg");
    endtask

    task automatic test_invalid();
        do_op(3'd0, W'(9), W'(9), "pre_invalid");
        for (int i = 5; i < 8; i++) do_op(3'(i), W'($urandom), W'($urandom), "invalid");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er;
        logic ec;
        int lat, n;
        model(3'd2, W'(123), -W'(45), er, ec, lat);
        @(negedge clk);
        start = 1'b1; op = 3'd2; tmp1 = W'(123); tmp2 = -W'(45);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == 3) begin start = 1'b1; op = 3'd0; tmp1 = W'(1); tmp2 = W'(1); end
            else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b1; op = 3'd0; tmp1 = W'(2); tmp2 = W'(2);
        total++;
        if (n != lat) begin bad++; $display("FAIL busy_start latency: got %0d want %0d", n, lat); end
        total++;
        if (result !== er || carry !== ec) begin
            bad++; $display("FAIL busy_start result: got %h/%b want %h/%b", result, carry, er, ec);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_at_done busy: got %b want 0", busy); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== er) begin
            bad++; $display("FAIL start_at_done idle: got busy=%b done=%b result=%h want 0 0 %h", busy, done, result, er);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) do_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), "random");
    endtask

    task automatic test_oe();
        do_op(3'd0, W'(100), W'(23), "pre_oe");
        oe = 1'b0;
        #1;
        total++;
`ifdef ALU_TRISTATE_EN
        if (result !== {W{1'bz}}) begin bad++; $display("FAIL oe_low: got %h want z", result); end
`else
        if (result !== W'(123)) begin bad++; $display("FAIL oe_low: got %h want %h", result, W'(123)); end
`endif
        total++;
        if (zero !== 1'b0 || sign !== 1'b0) begin bad++; $display("FAIL oe_flags: got zero=%b sign=%b want 0 0", zero, sign); end
        oe = 1'b1;
        #1;
        total++;
        if (result !== W'(123)) begin bad++; $display("FAIL oe_high: got %h want %h", result, W'(123)); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div_mod();
        test_invalid();
        test_back_to_back();
        test_random();
        test_oe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
